// File: rtl/packer_if.sv
// packer_if: narrow word stream in, wide packet beats out.
//
// Handshake: an input word moves on val && ready and an output beat moves on
// o_val && o_ready. The valid side never waits on the ready side, and a valid
// beat holds all of its fields stable until it transfers.
interface packer_if #(
    parameter int WORD_BYTES = 32,
    parameter int MAX_WORDS  = 5
);
    // Input word stream
    logic                               val;
    logic                               sop;
    logic                               eop;
    logic [7:0]                         vbc;
    logic [WORD_BYTES*8-1:0]            data;
    logic                               ready;

    // Output beat stream
    logic                               o_val;
    logic                               o_sop;
    logic                               o_eop;
    logic [7:0]                         o_vbc;
    logic [WORD_BYTES*MAX_WORDS*8-1:0]  o_data;
    logic                               o_ready;

    // Packer side
    modport slave (
        input  val, sop, eop, vbc, data, o_ready,
        output ready, o_val, o_sop, o_eop, o_vbc, o_data
    );

    // Environment side: word source and beat sink
    modport master (
        output val, sop, eop, vbc, data, o_ready,
        input  ready, o_val, o_sop, o_eop, o_vbc, o_data
    );
endinterface

// File: rtl/packer_fsm.sv
// packer_fsm: accumulates up to MAX_WORDS narrow words into one wide beat.
// The newest word always enters slot 0 and older words shift upward, so the
// first word of an n-word beat sits in slot n-1.
// Optional feature macro: PACKER_ZERO_FILL_EN (accumulator cleared on every
// emitted beat, so unused upper slots read as zero).
module packer_fsm #(
    parameter int WORD_BYTES = 32,
    parameter int MAX_WORDS  = 5
) (
    input  logic       clk,
    input  logic       reset_L,
    packer_if.slave    bus,
    output logic       idle,
    output logic       err,
    output logic       fsm_state
);
    localparam int WW = WORD_BYTES * 8;
    localparam int BW = WORD_BYTES * MAX_WORDS * 8;
    localparam int CW = $clog2(MAX_WORDS + 1);

    typedef enum logic {
        IDLE = 1'b0,
        PKT  = 1'b1
    } state_t;

    state_t         state, state_n;
    logic [CW-1:0]  cnt, cnt_n;
    logic [7:0]     bytes, bytes_n;
    logic           first, first_n;
    logic [BW-1:0]  acc, acc_n;
    logic           err_n;

    logic           o_val_n, o_sop_n, o_eop_n;
    logic [7:0]     o_vbc_n;
    logic [BW-1:0]  o_data_n;

    // Starting point for the word being packed; differs from the live state
    // only when a sop restarts a packet.
    logic [CW-1:0]  cnt_base;
    logic [7:0]     bytes_base;
    logic           first_base;
    logic [BW-1:0]  acc_base;
    logic           accept;

    // Input is open whenever the output register is empty or draining now
    assign bus.ready = !bus.o_val || bus.o_ready;
    assign accept    = bus.val && bus.ready;

    assign idle      = (state == IDLE) && !bus.o_val && (cnt == '0);
    assign fsm_state = state;

    // Next-state, accumulator and output-register computation
    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        bytes_n    = bytes;
        first_n    = first;
        acc_n      = acc;
        err_n      = err;
        o_val_n    = bus.o_val && !bus.o_ready;
        o_sop_n    = bus.o_sop;
        o_eop_n    = bus.o_eop;
        o_vbc_n    = bus.o_vbc;
        o_data_n   = bus.o_data;
        cnt_base   = cnt;
        bytes_base = bytes;
        first_base = first;
        acc_base   = acc;

        if (accept) begin
            if (bus.vbc > 8'(WORD_BYTES)) begin
                // Oversized word cannot be framed; drop it
                err_n = 1'b1;
            end else if (bus.vbc == 8'd0) begin
                // Empty word: consumed silently
            end else if ((state == IDLE) && !bus.sop) begin
                // Stray word outside any packet; drop it
                err_n = 1'b1;
            end else begin
                if (bus.sop) begin
                    // A sop while a packet is open abandons the open packet
                    if (state == PKT) begin
                        err_n = 1'b1;
                    end
                    cnt_base   = '0;
                    bytes_base = 8'd0;
                    first_base = 1'b1;
`ifdef PACKER_ZERO_FILL_EN
                    acc_base   = '0;
`endif
                end

                // Short words are only legal at end of packet
                if (!bus.eop && (bus.vbc < 8'(WORD_BYTES))) begin
                    err_n = 1'b1;
                end

                acc_n   = (acc_base << WW) | BW'(bus.data);
                cnt_n   = cnt_base + CW'(1);
                bytes_n = bytes_base + bus.vbc;
                first_n = first_base;
                state_n = bus.eop ? IDLE : PKT;

                if (bus.eop || (cnt_n == CW'(MAX_WORDS))) begin
                    o_val_n  = 1'b1;
                    o_sop_n  = first_n;
                    o_eop_n  = bus.eop;
                    o_vbc_n  = bytes_n;
                    o_data_n = acc_n;
                    cnt_n    = '0;
                    bytes_n  = 8'd0;
                    first_n  = 1'b0;
`ifdef PACKER_ZERO_FILL_EN
                    acc_n    = '0;
`endif
                end
            end
        end
    end

    // State, accumulator and output registers
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state      <= IDLE;
            cnt        <= '0;
            bytes      <= 8'd0;
            first      <= 1'b0;
            acc        <= '0;
            err        <= 1'b0;
            bus.o_val  <= 1'b0;
            bus.o_sop  <= 1'b0;
            bus.o_eop  <= 1'b0;
            bus.o_vbc  <= 8'd0;
            bus.o_data <= '0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            bytes      <= bytes_n;
            first      <= first_n;
            acc        <= acc_n;
            err        <= err_n;
            bus.o_val  <= o_val_n;
            bus.o_sop  <= o_sop_n;
            bus.o_eop  <= o_eop_n;
            bus.o_vbc  <= o_vbc_n;
            bus.o_data <= o_data_n;
        end
    end
endmodule

// File: tb/tb_packer_fsm.sv
// tb_packer_fsm: directed scenarios for packer_fsm with hand-computed beats.
module tb_packer_fsm;
    localparam int WB = 32;
    localparam int MW = 5;
    localparam int WW = WB * 8;
    localparam int BW = WB * MW * 8;

    logic clk;
    logic reset_L;
    logic idle;
    logic err;
    logic fsm_state;
    int   tests;
    int   fails;

    packer_if #(.WORD_BYTES(WB), .MAX_WORDS(MW)) ifc ();

    packer_fsm #(.WORD_BYTES(WB), .MAX_WORDS(MW)) dut (
        .clk       (clk),
        .reset_L   (reset_L),
        .bus       (ifc),
        .idle      (idle),
        .err       (err),
        .fsm_state (fsm_state)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Word whose every byte equals the tag
    function automatic logic [WW-1:0] w(input int tag);
        logic [7:0] b;
        b = tag[7:0];
        return {WB{b}};
    endfunction

    function automatic logic [WW-1:0] slot(input int k);
        return ifc.o_data[k*WW +: WW];
    endfunction

    // Pulse reset, leave inputs idle, return at posedge+1 with reset released
    task automatic apply_reset();
        ifc.val = 1'b0;
        reset_L = 1'b0;
        @(posedge clk); #1;
        reset_L = 1'b1;
        @(posedge clk); #1;
    endtask

    // Present one word and return at posedge+1 after it was accepted
    task automatic send_word(input logic s, input logic e, input logic [7:0] v, input int tag);
        int waited;
        ifc.val  = 1'b1;
        ifc.sop  = s;
        ifc.eop  = e;
        ifc.vbc  = v;
        ifc.data = w(tag);
        waited   = 0;
        while (!ifc.ready && waited < 50) begin
            @(posedge clk); #1;
            waited++;
        end
        if (!ifc.ready) begin
            tests++; fails++;
            $display("FAIL send_timeout: ready got %b expected 1 after %0d cycles", ifc.ready, waited);
        end
        @(posedge clk); #1;
        ifc.val = 1'b0;
    endtask

    task automatic test_reset();
        reset_L = 1'b0;
        #1;
        tests++; if (ifc.o_val !== 1'b0) begin fails++; $display("FAIL rst_o_val: got %b expected 0", ifc.o_val); end
        tests++; if (ifc.o_vbc !== 8'd0) begin fails++; $display("FAIL rst_o_vbc: got %0d expected 0", ifc.o_vbc); end
        tests++; if (ifc.o_data !== '0) begin fails++; $display("FAIL rst_o_data: got %0h expected 0", ifc.o_data); end
        tests++; if ({ifc.o_sop, ifc.o_eop} !== 2'b00) begin fails++; $display("FAIL rst_sop_eop: got %b expected 00", {ifc.o_sop, ifc.o_eop}); end
        tests++; if (err !== 1'b0) begin fails++; $display("FAIL rst_err: got %b expected 0", err); end
        tests++; if (idle !== 1'b1) begin fails++; $display("FAIL rst_idle: got %b expected 1", idle); end
        tests++; if (ifc.ready !== 1'b1) begin fails++; $display("FAIL rst_ready: got %b expected 1", ifc.ready); end
        tests++; if (fsm_state !== 1'b0) begin fails++; $display("FAIL rst_state: got %b expected 0", fsm_state); end
        @(posedge clk); #1;
        reset_L = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_160();
        send_word(1'b1, 1'b0, 8'd32, 1);
        send_word(1'b0, 1'b0, 8'd32, 2);
        send_word(1'b0, 1'b0, 8'd32, 3);
        send_word(1'b0, 1'b0, 8'd32, 4);
        tests++; if (ifc.o_val !== 1'b0) begin fails++; $display("FAIL p160_early: o_val got %b expected 0", ifc.o_val); end
        send_word(1'b0, 1'b1, 8'd32, 5);
        tests++; if (ifc.o_val !== 1'b1) begin fails++; $display("FAIL p160_val: got %b expected 1", ifc.o_val); end
        tests++; if (ifc.o_vbc !== 8'd160) begin fails++; $display("FAIL p160_vbc: got %0d expected 160", ifc.o_vbc); end
        tests++; if ({ifc.o_sop, ifc.o_eop} !== 2'b11) begin fails++; $display("FAIL p160_sop_eop: got %b expected 11", {ifc.o_sop, ifc.o_eop}); end
        tests++; if (slot(4) !== w(1)) begin fails++; $display("FAIL p160_slot4: got %0h expected %0h", slot(4), w(1)); end
        tests++; if (slot(0) !== w(5)) begin fails++; $display("FAIL p160_slot0: got %0h expected %0h", slot(0), w(5)); end
        @(posedge clk); #1;
        tests++; if (ifc.o_val !== 1'b0 || idle !== 1'b1) begin fails++; $display("FAIL p160_drain: o_val/idle got %b%b expected 01", ifc.o_val, idle); end
    endtask

    task automatic test_200();
        send_word(1'b1, 1'b0, 8'd32, 10);
        for (int i = 11; i <= 14; i++) send_word(1'b0, 1'b0, 8'd32, i);
        tests++; if (ifc.o_val !== 1'b1 || ifc.o_vbc !== 8'd160) begin fails++; $display("FAIL p200_b1_vbc: val/vbc got %b/%0d expected 1/160", ifc.o_val, ifc.o_vbc); end
        tests++; if ({ifc.o_sop, ifc.o_eop} !== 2'b10) begin fails++; $display("FAIL p200_b1_sop_eop: got %b expected 10", {ifc.o_sop, ifc.o_eop}); end
        tests++; if (slot(4) !== w(10)) begin fails++; $display("FAIL p200_b1_slot4: got %0h expected %0h", slot(4), w(10)); end
        send_word(1'b0, 1'b0, 8'd32, 15);
        tests++; if (ifc.o_val !== 1'b0) begin fails++; $display("FAIL p200_gap: o_val got %b expected 0", ifc.o_val); end
        send_word(1'b0, 1'b1, 8'd8, 16);
        tests++; if (ifc.o_val !== 1'b1 || ifc.o_vbc !== 8'd40) begin fails++; $display("FAIL p200_b2_vbc: val/vbc got %b/%0d expected 1/40", ifc.o_val, ifc.o_vbc); end
        tests++; if ({ifc.o_sop, ifc.o_eop} !== 2'b01) begin fails++; $display("FAIL p200_b2_sop_eop: got %b expected 01", {ifc.o_sop, ifc.o_eop}); end
        tests++; if (slot(0) !== w(16) || slot(1) !== w(15)) begin fails++; $display("FAIL p200_b2_slots: got %0h/%0h expected %0h/%0h", slot(1), slot(0), w(15), w(16)); end
        tests++; if (err !== 1'b0) begin fails++; $display("FAIL p200_err: got %b expected 0", err); end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        int bad;
        ifc.o_ready = 1'b0;
        send_word(1'b1, 1'b1, 8'd32, 20);
        ifc.val  = 1'b1;
        ifc.sop  = 1'b1;
        ifc.eop  = 1'b1;
        ifc.vbc  = 8'd16;
        ifc.data = w(21);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            tests++;
            if (ifc.ready !== 1'b0 || ifc.o_val !== 1'b1 || ifc.o_vbc !== 8'd32 || slot(0) !== w(20)) begin
                fails++; bad++;
                if (bad == 1) $display("FAIL bp_hold: cycle %0d ready/o_val/o_vbc got %b/%b/%0d expected 0/1/32", i, ifc.ready, ifc.o_val, ifc.o_vbc);
            end
            @(posedge clk); #1;
        end
        ifc.o_ready = 1'b1;
        #1;
        tests++; if (ifc.ready !== 1'b1) begin fails++; $display("FAIL bp_ready_comb: got %b expected 1", ifc.ready); end
        @(posedge clk); #1;
        ifc.val = 1'b0;
        tests++; if (ifc.o_val !== 1'b1 || ifc.o_vbc !== 8'd16) begin fails++; $display("FAIL bp_next_beat: val/vbc got %b/%0d expected 1/16", ifc.o_val, ifc.o_vbc); end
        tests++; if (slot(0) !== w(21)) begin fails++; $display("FAIL bp_next_slot0: got %0h expected %0h", slot(0), w(21)); end
        @(posedge clk); #1;
        tests++; if (ifc.o_val !== 1'b0) begin fails++; $display("FAIL bp_drain: o_val got %b expected 0", ifc.o_val); end
    endtask

    task automatic test_single_byte();
        send_word(1'b1, 1'b1, 8'd1, 60);
        tests++; if (ifc.o_val !== 1'b1 || ifc.o_vbc !== 8'd1) begin fails++; $display("FAIL one_vbc: val/vbc got %b/%0d expected 1/1", ifc.o_val, ifc.o_vbc); end
        tests++; if (slot(0) !== w(60) || {ifc.o_sop, ifc.o_eop} !== 2'b11) begin fails++; $display("FAIL one_slot0: got %0h sop/eop %b expected %0h 11", slot(0), {ifc.o_sop, ifc.o_eop}, w(60)); end
`ifdef PACKER_ZERO_FILL_EN
        tests++; if (ifc.o_data[BW-1:WW] !== '0) begin fails++; $display("FAIL one_zero_fill: upper got %0h expected 0", ifc.o_data[BW-1:WW]); end
`endif
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        send_word(1'b1, 1'b0, 8'd32, 70);
        send_word(1'b0, 1'b0, 8'd32, 71);
        send_word(1'b0, 1'b0, 8'd32, 72);
        reset_L = 1'b0;
        #1;
        tests++; if (ifc.o_val !== 1'b0 || idle !== 1'b1) begin fails++; $display("FAIL rmid_drop: o_val/idle got %b%b expected 01", ifc.o_val, idle); end
        @(posedge clk); #1;
        reset_L = 1'b1;
        @(posedge clk); #1;
        send_word(1'b1, 1'b0, 8'd32, 80);
        tests++; if (ifc.o_val !== 1'b0) begin fails++; $display("FAIL rmid_stale: o_val got %b expected 0", ifc.o_val); end
        send_word(1'b0, 1'b1, 8'd32, 81);
        tests++; if (ifc.o_val !== 1'b1 || ifc.o_vbc !== 8'd64 || {ifc.o_sop, ifc.o_eop} !== 2'b11) begin fails++; $display("FAIL rmid_beat: val/vbc/sopeop got %b/%0d/%b expected 1/64/11", ifc.o_val, ifc.o_vbc, {ifc.o_sop, ifc.o_eop}); end
        tests++; if (slot(1) !== w(80) || slot(0) !== w(81)) begin fails++; $display("FAIL rmid_slots: got %0h/%0h expected %0h/%0h", slot(1), slot(0), w(80), w(81)); end
        tests++; if (err !== 1'b0) begin fails++; $display("FAIL rmid_err: got %b expected 0", err); end
        @(posedge clk); #1;
    endtask

    task automatic test_err_sop();
        send_word(1'b1, 1'b0, 8'd32, 30);
        send_word(1'b0, 1'b0, 8'd32, 31);
        tests++; if (err !== 1'b0) begin fails++; $display("FAIL esop_pre: err got %b expected 0", err); end
        send_word(1'b1, 1'b0, 8'd32, 40);
        tests++; if (err !== 1'b1) begin fails++; $display("FAIL esop_err: got %b expected 1", err); end
        send_word(1'b0, 1'b1, 8'd32, 41);
        tests++; if (ifc.o_val !== 1'b1 || ifc.o_vbc !== 8'd64 || {ifc.o_sop, ifc.o_eop} !== 2'b11) begin fails++; $display("FAIL esop_beat: val/vbc/sopeop got %b/%0d/%b expected 1/64/11", ifc.o_val, ifc.o_vbc, {ifc.o_sop, ifc.o_eop}); end
        tests++; if (slot(1) !== w(40) || slot(0) !== w(41)) begin fails++; $display("FAIL esop_slots: got %0h/%0h expected %0h/%0h", slot(1), slot(0), w(40), w(41)); end
`ifdef PACKER_ZERO_FILL_EN
        tests++; if (ifc.o_data[BW-1:2*WW] !== '0) begin fails++; $display("FAIL esop_zero_fill: upper got %0h expected 0", ifc.o_data[BW-1:2*WW]); end
`endif
        @(posedge clk); #1;
    endtask

    task automatic test_err_vbc();
        apply_reset();
        tests++; if (err !== 1'b0) begin fails++; $display("FAIL evbc_clear: err got %b expected 0", err); end
        send_word(1'b1, 1'b0, 8'd32, 50);
        send_word(1'b0, 1'b0, 8'd40, 51);
        tests++; if (err !== 1'b1) begin fails++; $display("FAIL evbc_err: got %b expected 1", err); end
        send_word(1'b0, 1'b1, 8'd32, 52);
        tests++; if (ifc.o_val !== 1'b1 || ifc.o_vbc !== 8'd64) begin fails++; $display("FAIL evbc_beat: val/vbc got %b/%0d expected 1/64", ifc.o_val, ifc.o_vbc); end
        tests++; if (slot(1) !== w(50) || slot(0) !== w(52)) begin fails++; $display("FAIL evbc_slots: got %0h/%0h expected %0h/%0h", slot(1), slot(0), w(50), w(52)); end
        @(posedge clk); #1;
    endtask

    initial begin
        tests       = 0;
        fails       = 0;
        reset_L     = 1'b0;
        ifc.val     = 1'b0;
        ifc.sop     = 1'b0;
        ifc.eop     = 1'b0;
        ifc.vbc     = 8'd0;
        ifc.data    = '0;
        ifc.o_ready = 1'b1;
        #2;
        test_reset();
        test_160();
        test_200();
        test_backpressure();
        test_single_byte();
        test_reset_mid();
        test_err_sop();
        test_err_vbc();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
